top_seg: RTL and testbench

//  - Four-digit stopwatch (SS.hh: seconds 00-99, hundredths 00-99) driving two 7-segment digit pairs.
//  - Each pair is time-multiplexed: seg_ab shows seconds, seg_cd shows hundredths.
//  - seg_en selects the tens or units digit of both pairs at the same time.
//  - Top-level board block; the 125 MHz board clock feeds it directly.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_decoder.sv | 26 ++
 rtl/top_seg.sv | 121 ++++++++++++
 tb/tb_top_seg.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the stopwatch display: digit-select encodings and the
// seven-segment glyph table ({g,f,e,d,c,b,a}, active-high).
package seg_pkg;

    typedef enum logic [1:0] {
        SEL_UNITS = 2'b01,
        SEL_TENS  = 2'b10
    } sel_t;

    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0000110;
    localparam logic [6:0] GLYPH_2     = 7'b1011011;
    localparam logic [6:0] GLYPH_3     = 7'b1001111;
    localparam logic [6:0] GLYPH_4     = 7'b1100110;
    localparam logic [6:0] GLYPH_5     = 7'b1101101;
    localparam logic [6:0] GLYPH_6     = 7'b1111101;
    localparam logic [6:0] GLYPH_7     = 7'b0000111;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1101111;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD digit to seven-segment glyph; non-decimal codes go blank.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_BLANK;
        case (digit)
            4'd0: glyph = GLYPH_0;
            4'd1: glyph = GLYPH_1;
            4'd2: glyph = GLYPH_2;
            4'd3: glyph = GLYPH_3;
            4'd4: glyph = GLYPH_4;
            4'd5: glyph = GLYPH_5;
            4'd6: glyph = GLYPH_6;
            4'd7: glyph = GLYPH_7;
            4'd8: glyph = GLYPH_8;
            4'd9: glyph = GLYPH_9;
            default: glyph = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/top_seg.sv
// Four-digit SS.hh stopwatch: run flag, tick and mux prescalers, cascaded BCD
// counter and registered, time-multiplexed seven-segment outputs.
module top_seg
    import seg_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 125_000_000,
    parameter int unsigned TICK_HZ = 100,
    parameter int unsigned MUX_HZ  = 1_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic [1:0] seg_en,
    output logic [6:0] seg_ab,
    output logic [6:0] seg_cd
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned MUX_DIV  = CLK_HZ / MUX_HZ;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MUX_W    = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [MUX_W-1:0]  MUX_LAST  = MUX_W'(MUX_DIV - 1);

    logic              run;
    logic [TICK_W-1:0] tick_cnt;
    logic [MUX_W-1:0]  mux_cnt;
    logic              tick;
    logic              mux_wrap;
    sel_t              sel;
    logic [3:0]        sec_tens, sec_units, hund_tens, hund_units;
    logic [3:0]        ab_digit, cd_digit;
    logic [6:0]        ab_glyph, cd_glyph;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
        end else if (stop) begin
            run <= 1'b0;
        end else if (start) begin
            run <= 1'b1;
        end
    end

    assign tick = run && (tick_cnt == TICK_LAST);

    // Held, not cleared, while paused so a resume finishes the partial tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (run) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hund_units <= '0;
            hund_tens  <= '0;
            sec_units  <= '0;
            sec_tens   <= '0;
        end else if (tick) begin
            if (hund_units >= 4'd9) begin
                hund_units <= '0;
                if (hund_tens >= 4'd9) begin
                    hund_tens <= '0;
                    if (sec_units >= 4'd9) begin
                        sec_units <= '0;
                        sec_tens  <= (sec_tens >= 4'd9) ? 4'd0 : sec_tens + 4'd1;
                    end else begin
                        sec_units <= sec_units + 4'd1;
                    end
                end else begin
                    hund_tens <= hund_tens + 4'd1;
                end
            end else begin
                hund_units <= hund_units + 4'd1;
            end
        end
    end

    assign mux_wrap = (mux_cnt == MUX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mux_cnt <= '0;
            sel     <= SEL_UNITS;
        end else begin
            mux_cnt <= mux_wrap ? '0 : mux_cnt + 1'b1;
            if (mux_wrap) begin
                sel <= (sel == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
            end
        end
    end

    assign seg_en   = sel;
    assign ab_digit = (sel == SEL_TENS) ? sec_tens  : sec_units;
    assign cd_digit = (sel == SEL_TENS) ? hund_tens : hund_units;

    seg_decoder u_dec_ab (
        .digit (ab_digit),
        .glyph (ab_glyph)
    );

    seg_decoder u_dec_cd (
        .digit (cd_digit),
        .glyph (cd_glyph)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_ab <= GLYPH_0;
            seg_cd <= GLYPH_0;
        end else begin
            seg_ab <= ab_glyph;
            seg_cd <= cd_glyph;
        end
    end

endmodule

// File: tb/tb_top_seg.sv
// Directed bench for top_seg at 4 clk per tick and 4 clk per mux phase,
// with hand-computed display values.
module tb_top_seg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] seg_en;
    logic [6:0] seg_ab;
    logic [6:0] seg_cd;

    int checks = 0;
    int failures = 0;

    logic [6:0] glyph_tab [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    top_seg #(
        .CLK_HZ  (1000),
        .TICK_HZ (250),
        .MUX_HZ  (250)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .seg_en (seg_en),
        .seg_ab (seg_ab),
        .seg_cd (seg_cd)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait for a fresh entry into the target phase, then one more clk for the
    // registered segments to follow.
    task automatic wait_phase(input string tag, input logic [1:0] target);
        int n = 0;
        while (seg_en == target && n < 20) begin
            step(1);
            n++;
        end
        while (seg_en != target && n < 20) begin
            step(1);
            n++;
        end
        if (seg_en != target) check_eq({tag, "_mux_timeout"}, {5'b0, seg_en}, {5'b0, target});
        step(1);
    endtask

    task automatic check_display(input string tag, input int st, input int su,
                                 input int ht, input int hu);
        wait_phase(tag, 2'b01);
        check_eq({tag, "_ab_units"}, seg_ab, glyph_tab[su]);
        check_eq({tag, "_cd_units"}, seg_cd, glyph_tab[hu]);
        wait_phase(tag, 2'b10);
        check_eq({tag, "_ab_tens"}, seg_ab, glyph_tab[st]);
        check_eq({tag, "_cd_tens"}, seg_cd, glyph_tab[ht]);
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; stop = 1'b0;
        step(5);
        check_eq("reset_en", {5'b0, seg_en}, 7'b0000001);
        check_eq("reset_ab", seg_ab, 7'b0111111);
        check_eq("reset_cd", seg_cd, 7'b0111111);

        start = 1'b0; rst = 1'b1;
        step(1);
        // 101 counting edges under start plus the edge that samples stop: 102 = 25 ticks + 2
        start = 1'b1;
        step(102);
        start = 1'b0; stop = 1'b1;
        step(1);
        check_display("run_0025", 0, 0, 2, 5);
        step(100);
        check_display("pause_0025", 0, 0, 2, 5);

        // resume: two counts finish the kept partial tick, the stop edge adds one
        stop = 1'b0; start = 1'b1;
        step(3);
        start = 1'b0; stop = 1'b1;
        step(1);
        check_display("partial_0026", 0, 0, 2, 6);

        start = 1'b1; stop = 1'b1;
        step(50);
        check_display("priority_0026", 0, 0, 2, 6);

        start = 1'b0; stop = 1'b0; rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(20);
        check_display("idle_0000", 0, 0, 0, 0);

        // 39995 counts under start + 1 on the stop edge = 9999 ticks
        start = 1'b1;
        step(39996);
        start = 1'b0; stop = 1'b1;
        step(1);
        check_display("full_9999", 9, 9, 9, 9);

        stop = 1'b0; start = 1'b1;
        step(4);
        start = 1'b0; stop = 1'b1;
        step(1);
        check_display("wrap_0000", 0, 0, 0, 0);

        stop = 1'b0; start = 1'b1;
        step(30);
        #2 rst = 1'b0;
        #1;
        check_eq("async_en", {5'b0, seg_en}, 7'b0000001);
        check_eq("async_ab", seg_ab, 7'b0111111);
        check_eq("async_cd", seg_cd, 7'b0111111);
        step(10);
        start = 1'b0; rst = 1'b1;
        step(20);
        check_display("after_reset", 0, 0, 0, 0);

        start = 1'b1;
        step(5);
        start = 1'b0; stop = 1'b1;
        step(1);
        check_display("restart_0001", 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
